fft_reorder_sink: RTL and testbench

FFT_REORDER_SINK -- requirements
Module: fft_reorder_sink

---
 rtl/fft_pkg.sv | 32 +++
 rtl/fft_reorder_sink_if.sv | 31 +++
 rtl/fft_sp_buf.sv | 32 +++
 rtl/fft_reorder_sink.sv | 172 +++++++++++++++++
 tb/tb_fft_reorder_sink.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder sink: precision default,
// FALCON frame sizes, drain state encoding and the bit-reverse helper.
package fft_pkg;

   localparam int FLOAT_PRECISION_DEFAULT = 64;
   localparam int LOGN_FALCON512          = 8;
   localparam int LOGN_FALCON1024         = 9;
   localparam int BITREV_MAX_W            = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // Reverses the low w bits of a; bits at and above w come back as zero.
   function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] a,
                                                      input int w);
      logic [BITREV_MAX_W-1:0] src;
      logic [BITREV_MAX_W-1:0] res;
      src = a;
      res = '0;
      for (int i = 0; i < BITREV_MAX_W; i++) begin
         if (i < w) begin
            res = {res[BITREV_MAX_W-2:0], src[0]};
            src = src >> 1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/fft_reorder_sink_if.sv
// Sample stream bundle for the reorder sink: FFT-facing input stream and
// downstream-facing output stream, each with valid/ready.
interface fft_reorder_sink_if
   import fft_pkg::*;
#(
   parameter int FLOAT_PRECISION = FLOAT_PRECISION_DEFAULT,
   parameter int logn            = LOGN_FALCON512
);

   logic                       in_valid;
   logic                       in_ready;
   logic [FLOAT_PRECISION-1:0] in_re;
   logic [FLOAT_PRECISION-1:0] in_im;
   logic                       out_valid;
   logic                       out_ready;
   logic [FLOAT_PRECISION-1:0] out_re;
   logic [FLOAT_PRECISION-1:0] out_im;
   logic [logn-1:0]            out_idx;
   logic                       out_last;

   modport master (
      output in_valid, in_re, in_im, out_ready,
      input  in_ready, out_valid, out_re, out_im, out_idx, out_last
   );

   modport slave (
      input  in_valid, in_re, in_im, out_ready,
      output in_ready, out_valid, out_re, out_im, out_idx, out_last
   );

endinterface

// File: rtl/fft_sp_buf.sv
// Frame buffer: one write port, one read port, registered read (1-cycle
// latency), plain array so synthesis infers block RAM.
module fft_sp_buf #(
   parameter int  WIDTH = 128,
   parameter int  DEPTH = 256,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // NOTE: no reset on the array or its read register; a reset would block RAM inference.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_reorder_sink.sv
// Collects one FFT frame in arrival order, then drains it in bit-reversed (or
// arrival) order through a RAM-read stage plus a two-entry output/skid pair.
module fft_reorder_sink
   import fft_pkg::*;
#(
   parameter int FLOAT_PRECISION = FLOAT_PRECISION_DEFAULT,
   parameter int logn            = LOGN_FALCON512,
   parameter bit BITREV          = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   fft_reorder_sink_if.slave bus,
   output logic              busy,
   output logic              ovf
);

   localparam int N = 1 << logn;
   localparam int W = 2 * FLOAT_PRECISION;
   localparam logic [logn:0] LAST_K = (logn + 1)'(N - 1);
   localparam logic [logn:0] N_CNT  = (logn + 1)'(N);

   typedef struct packed {
      logic [W-1:0]    data;
      logic [logn-1:0] idx;
      logic            last;
   } beat_t;

   state_e          state_q, state_d;
   logic [logn:0]   wr_cnt_q, wr_cnt_d;
   logic [logn:0]   rd_cnt_q, rd_cnt_d;
   logic            ovf_q, ovf_d;
   logic            ram_vld_q, ram_vld_d;
   logic [logn-1:0] ram_idx_q, ram_idx_d;
   logic            ram_last_q, ram_last_d;
   logic            skid_vld_q, skid_vld_d;
   beat_t           skid_q, skid_d;
   logic            out_vld_q, out_vld_d;
   beat_t           out_q, out_d;

   logic            in_ready, accept, pop, rd_room, rd_en;
   logic [1:0]      pending;
   logic [logn-1:0] rd_addr;
   logic [W-1:0]    rd_data;
   beat_t           ram_beat;

   assign in_ready = (state_q != ST_DRAIN);
   assign accept   = bus.in_valid & in_ready;
   assign pop      = out_vld_q & bus.out_ready;

   // A read is issued only if its data is guaranteed a slot in out/skid on arrival.
   assign pending = 2'(ram_vld_q) + 2'(skid_vld_q) + 2'(out_vld_q);
   assign rd_room = (pending < 2'd2) | pop;
   assign rd_en   = (state_q == ST_DRAIN) & (rd_cnt_q < N_CNT) & rd_room;
   assign rd_addr = BITREV ? logn'(bitrev(BITREV_MAX_W'(rd_cnt_q[logn-1:0]), logn))
                           : rd_cnt_q[logn-1:0];

   fft_sp_buf #(
      .WIDTH (W),
      .DEPTH (N)
   ) u_buf (
      .clk     (clk),
      .wr_en   (accept),
      .wr_addr (wr_cnt_q[logn-1:0]),
      .wr_data ({bus.in_re, bus.in_im}),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_comb begin
      // NOTE: every _d gets its hold value first, so no branch can infer a latch.
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      ovf_d    = ovf_q | (bus.in_valid & ~in_ready);
      case (state_q)
         ST_IDLE, ST_FILL: begin
            if (accept) begin
               if (wr_cnt_q == LAST_K) begin
                  state_d  = ST_DRAIN;
                  wr_cnt_d = '0;
                  rd_cnt_d = '0;
               end else begin
                  state_d  = ST_FILL;
                  wr_cnt_d = wr_cnt_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (rd_en) begin
               rd_cnt_d = rd_cnt_q + 1'b1;
            end
            if (pop && out_q.last) begin
               state_d  = ST_IDLE;
               rd_cnt_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ram_vld_d     = rd_en;
      ram_idx_d     = rd_addr;
      ram_last_d    = (rd_cnt_q == LAST_K);
      ram_beat.data = rd_data;
      ram_beat.idx  = ram_idx_q;
      ram_beat.last = ram_last_q;
      out_d         = out_q;
      out_vld_d     = out_vld_q;
      skid_d        = skid_q;
      skid_vld_d    = skid_vld_q;
      // Output register refills from skid first, keeping delivery in read order.
      if (!out_vld_q || pop) begin
         if (skid_vld_q) begin
            out_d      = skid_q;
            out_vld_d  = 1'b1;
            skid_vld_d = ram_vld_q;
            if (ram_vld_q) begin
               skid_d = ram_beat;
            end
         end else begin
            out_vld_d = ram_vld_q;
            if (ram_vld_q) begin
               out_d = ram_beat;
            end
         end
      end else if (ram_vld_q) begin
         skid_d     = ram_beat;
         skid_vld_d = 1'b1;
      end
   end

   // NOTE: flops use <= so every register samples pre-edge values; combinational blocks use =.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         ovf_q      <= 1'b0;
         ram_vld_q  <= 1'b0;
         ram_idx_q  <= '0;
         ram_last_q <= 1'b0;
         skid_vld_q <= 1'b0;
         skid_q     <= '0;
         out_vld_q  <= 1'b0;
         out_q      <= '0;
      end else begin
         state_q    <= state_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         ovf_q      <= ovf_d;
         ram_vld_q  <= ram_vld_d;
         ram_idx_q  <= ram_idx_d;
         ram_last_q <= ram_last_d;
         skid_vld_q <= skid_vld_d;
         skid_q     <= skid_d;
         out_vld_q  <= out_vld_d;
         out_q      <= out_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_vld_q;
   assign bus.out_re    = out_q.data[W-1:FLOAT_PRECISION];
   assign bus.out_im    = out_q.data[FLOAT_PRECISION-1:0];
   assign bus.out_idx   = out_q.idx;
   assign bus.out_last  = out_vld_q & out_q.last;
   assign busy          = (state_q != ST_IDLE);
   assign ovf           = ovf_q;

endmodule

// File: tb/tb_fft_reorder_sink.sv
// Directed bench: two 8-point sinks (bit-reversed and arrival order) sharing
// stimulus, plus a 256-point sink run with two back-to-back random frames.
module tb_fft_reorder_sink;

   localparam int FP = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          s_in_valid, s_out_ready;
   logic [FP-1:0] s_in_re, s_in_im;
   logic          c_in_valid, c_out_ready;
   logic [FP-1:0] c_in_re, c_in_im;
   logic          a_busy, a_ovf, b_busy, b_ovf, c_busy, c_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   fft_reorder_sink_if #(.FLOAT_PRECISION(FP), .logn(3)) if_a ();
   fft_reorder_sink_if #(.FLOAT_PRECISION(FP), .logn(3)) if_b ();
   fft_reorder_sink_if #(.FLOAT_PRECISION(FP), .logn(8)) if_c ();

   assign if_a.in_valid  = s_in_valid;
   assign if_a.in_re     = s_in_re;
   assign if_a.in_im     = s_in_im;
   assign if_a.out_ready = s_out_ready;
   assign if_b.in_valid  = s_in_valid;
   assign if_b.in_re     = s_in_re;
   assign if_b.in_im     = s_in_im;
   assign if_b.out_ready = s_out_ready;
   assign if_c.in_valid  = c_in_valid;
   assign if_c.in_re     = c_in_re;
   assign if_c.in_im     = c_in_im;
   assign if_c.out_ready = c_out_ready;

   fft_reorder_sink #(.FLOAT_PRECISION(FP), .logn(3), .BITREV(1'b1)) dut_a (
      .clk(clk), .rst(rst), .bus(if_a), .busy(a_busy), .ovf(a_ovf));
   fft_reorder_sink #(.FLOAT_PRECISION(FP), .logn(3), .BITREV(1'b0)) dut_b (
      .clk(clk), .rst(rst), .bus(if_b), .busy(b_busy), .ovf(b_ovf));
   fft_reorder_sink #(.FLOAT_PRECISION(FP), .logn(8), .BITREV(1'b1)) dut_c (
      .clk(clk), .rst(rst), .bus(if_c), .busy(c_busy), .ovf(c_ovf));

   typedef struct {
      logic [63:0] in_re;
      logic [63:0] in_im;
      logic [63:0] exp_a_re;
      logic [63:0] exp_a_im;
      logic [2:0]  exp_a_idx;
      logic [63:0] exp_b_re;
      logic [63:0] exp_b_im;
      logic [2:0]  exp_b_idx;
      logic        exp_last;
   } vec_t;

   vec_t tbl [8];
   int   a_order [8];

   logic [63:0] c_re [512];
   logic [63:0] c_im [512];
   int c_sent, c_rcvd, c_runs, c_low, c_cyc, c_f, c_j, c_a;
   int run_len [2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int tb_bitrev(input int v, input int bits);
      int r;
      r = 0;
      for (int i = 0; i < bits; i++) begin
         r = r * 2 + ((v >> i) & 1);
      end
      return r;
   endfunction

   task automatic fill_small(input logic [63:0] base, input int n);
      for (int k = 0; k < n; k++) begin
         check("fill_in_ready", 64'(if_a.in_ready), 64'd1);
         s_in_valid = 1'b1;
         s_in_re    = base + tbl[k].in_re;
         s_in_im    = base + tbl[k].in_im;
         tick();
      end
      s_in_valid = 1'b0;
   endtask

   // Starts right after the edge that accepted sample 7 (drain cycle 0).
   task automatic drain_small(input logic [63:0] base, input bit toggle_ready,
                              input int inject_at, input bit inject_last, input bit chk_b);
      int          got = 0;
      int          cyc = 0;
      int          first_valid = -1;
      bit          hold = 1'b0;
      bit          hs;
      logic [63:0] held_re, held_im;
      logic [2:0]  held_idx;
      logic        held_last;
      while (got < 8 && cyc < 100) begin
         if (if_a.out_valid && first_valid < 0) first_valid = cyc;
         if (hold) begin
            check("hold_valid", 64'(if_a.out_valid), 64'd1);
            check("hold_re", if_a.out_re, held_re);
            check("hold_im", if_a.out_im, held_im);
            check("hold_idx", 64'(if_a.out_idx), 64'(held_idx));
            check("hold_last", 64'(if_a.out_last), 64'(held_last));
         end
         s_out_ready = toggle_ready ? logic'(cyc % 3 == 0) : 1'b1;
         hs          = if_a.out_valid && s_out_ready;
         s_in_valid  = (cyc == inject_at) || (inject_last && hs && got == 7);
         s_in_re     = 64'd99;
         s_in_im     = 64'd99;
         if (hs) begin
            check("a_re", if_a.out_re, base + tbl[got].exp_a_re);
            check("a_im", if_a.out_im, base + tbl[got].exp_a_im);
            check("a_idx", 64'(if_a.out_idx), 64'(tbl[got].exp_a_idx));
            check("a_last", 64'(if_a.out_last), 64'(tbl[got].exp_last));
            if (chk_b) begin
               check("b_valid", 64'(if_b.out_valid), 64'd1);
               check("b_re", if_b.out_re, base + tbl[got].exp_b_re);
               check("b_im", if_b.out_im, base + tbl[got].exp_b_im);
               check("b_idx", 64'(if_b.out_idx), 64'(tbl[got].exp_b_idx));
               check("b_last", 64'(if_b.out_last), 64'(tbl[got].exp_last));
            end
            got++;
            hold = 1'b0;
         end else begin
            hold      = if_a.out_valid;
            held_re   = if_a.out_re;
            held_im   = if_a.out_im;
            held_idx  = if_a.out_idx;
            held_last = if_a.out_last;
         end
         tick();
         cyc++;
      end
      s_in_valid  = 1'b0;
      s_out_ready = 1'b1;
      check("drain_count", 64'(got), 64'd8);
      check("first_valid_latency", 64'(first_valid), 64'd2);
      check("post_drain_busy", 64'(a_busy), 64'd0);
      check("post_drain_in_ready", 64'(if_a.in_ready), 64'd1);
      check("post_drain_out_valid", 64'(if_a.out_valid), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      s_in_valid  = 1'b0;
      s_in_re     = '0;
      s_in_im     = '0;
      s_out_ready = 1'b1;
      c_in_valid  = 1'b0;
      c_in_re     = '0;
      c_in_im     = '0;
      c_out_ready = 1'b1;

      a_order = '{0, 4, 2, 6, 1, 5, 3, 7};
      for (int j = 0; j < 8; j++) begin
         tbl[j].in_re     = 64'(j);
         tbl[j].in_im     = 64'(100 + j);
         tbl[j].exp_a_re  = 64'(a_order[j]);
         tbl[j].exp_a_im  = 64'(100 + a_order[j]);
         tbl[j].exp_a_idx = 3'(a_order[j]);
         tbl[j].exp_b_re  = 64'(j);
         tbl[j].exp_b_im  = 64'(100 + j);
         tbl[j].exp_b_idx = 3'(j);
         tbl[j].exp_last  = (j == 7);
      end

      tick();
      tick();
      check("rst_out_valid", 64'(if_a.out_valid), 64'd0);
      check("rst_out_last", 64'(if_a.out_last), 64'd0);
      check("rst_in_ready", 64'(if_a.in_ready), 64'd1);
      check("rst_busy", 64'(a_busy), 64'd0);
      check("rst_ovf", 64'(a_ovf), 64'd0);
      check("rst_out_re", if_a.out_re, 64'd0);
      check("rst_out_im", if_a.out_im, 64'd0);
      check("rst_out_idx", 64'(if_a.out_idx), 64'd0);
      check("rst_c_in_ready", 64'(if_c.in_ready), 64'd1);
      rst = 1'b0;
      tick();

      // Basic frame on both orderings, out_ready held high.
      fill_small(64'd0, 8);
      check("drain_busy", 64'(a_busy), 64'd1);
      check("drain_in_ready", 64'(if_a.in_ready), 64'd0);
      drain_small(64'd0, 1'b0, -1, 1'b0, 1'b1);

      // Backpressure 1,0,0,... during drain.
      fill_small(64'd1000, 8);
      drain_small(64'd1000, 1'b1, -1, 1'b0, 1'b0);
      check("ovf_clean", 64'(a_ovf), 64'd0);

      // Input pulse during drain is dropped and flagged.
      fill_small(64'd2000, 8);
      drain_small(64'd2000, 1'b0, 3, 1'b0, 1'b0);
      check("ovf_set", 64'(a_ovf), 64'd1);
      fill_small(64'd3000, 8);
      drain_small(64'd3000, 1'b0, -1, 1'b0, 1'b0);
      check("ovf_sticky", 64'(a_ovf), 64'd1);

      // Reset mid-fill, then a fresh frame.
      fill_small(64'd4000, 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_ovf", 64'(a_ovf), 64'd0);
      check("midrst_busy", 64'(a_busy), 64'd0);
      check("midrst_in_ready", 64'(if_a.in_ready), 64'd1);
      check("midrst_out_valid", 64'(if_a.out_valid), 64'd0);
      tick();
      // Fresh frame also hits in_valid on the last-output handshake.
      fill_small(64'd5000, 8);
      drain_small(64'd5000, 1'b0, -1, 1'b1, 1'b0);
      check("last_hs_ovf", 64'(a_ovf), 64'd1);
      tick();
      check("last_hs_no_frame_busy", 64'(a_busy), 64'd0);
      check("last_hs_no_frame_valid", 64'(if_a.out_valid), 64'd0);

      // 256-point sink: two back-to-back random frames.
      for (int i = 0; i < 512; i++) begin
         c_re[i] = {$urandom(), $urandom()};
         c_im[i] = {$urandom(), $urandom()};
      end
      c_sent     = 0;
      c_rcvd     = 0;
      c_runs     = 0;
      c_low      = 0;
      c_cyc      = 0;
      run_len[0] = 0;
      run_len[1] = 0;
      while (c_runs < 2 && c_cyc < 3000) begin
         if (if_c.out_valid) begin
            c_f = c_rcvd / 256;
            c_j = c_rcvd % 256;
            c_a = tb_bitrev(c_j, 8);
            check("c_re", if_c.out_re, c_re[c_f * 256 + c_a]);
            check("c_im", if_c.out_im, c_im[c_f * 256 + c_a]);
            check("c_idx", 64'(if_c.out_idx), 64'(c_a));
            check("c_last", 64'(if_c.out_last), 64'(c_j == 255));
            c_rcvd++;
         end
         if (!if_c.in_ready) begin
            c_low++;
         end else if (c_low > 0) begin
            run_len[c_runs] = c_low;
            c_runs++;
            c_low = 0;
         end
         if (if_c.in_ready && c_sent < 512) begin
            c_in_valid = 1'b1;
            c_in_re    = c_re[c_sent];
            c_in_im    = c_im[c_sent];
            c_sent++;
         end else begin
            c_in_valid = 1'b0;
         end
         tick();
         c_cyc++;
      end
      c_in_valid = 1'b0;
      check("c_rcvd", 64'(c_rcvd), 64'd512);
      check("c_ready_low_frame0", 64'(run_len[0]), 64'd258);
      check("c_ready_low_frame1", 64'(run_len[1]), 64'd258);
      check("c_ovf", 64'(c_ovf), 64'd0);
      check("c_busy_end", 64'(c_busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
